// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin front end that shares one I2C master engine
// between NUM_REQ on-chip requesters, one 7-bit-address/1-byte write at a time.
// Flow: IDLE (pick winner, latch addr/data/id) -> ISSUE (grant + start)
//       -> WAIT (until m_done) -> RESP (tagged done/error) -> IDLE.
// All outputs are registered, so each output lags the state that produces it
// by one cycle (grant/m_start appear in the first WAIT cycle, resp_valid in
// the cycle after RESP).
// Optional feature macro: I2C_ARB_TIMEOUT_EN -- when defined, a WAIT that
// lasts TIMEOUT_CYC cycles without m_done pulses m_abort and completes with
// resp_error=1. When undefined, no counter exists and m_abort is tied low.
module i2c_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic                 clock,
  input  logic                 reset_L,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_error,
  output logic                 m_start,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_data,
  input  logic                 m_done,
  input  logic                 m_error,
  output logic                 m_abort
);

  // Reject configurations the index/pointer logic cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < $clog2(NUM_REQ) || TIMEOUT_CYC < 2) begin : g_param_check
    $error("i2c_bus_arbiter: unsupported NUM_REQ/ID_W/TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;      // highest-priority requester
  logic [ID_W-1:0]      id_q, id_d;        // latched winner, also drives resp_id
  logic [6:0]           addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic                 err_q, err_d;      // outcome captured in WAIT
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 start_q, start_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rerr_q, rerr_d;

  // Arbitration helpers
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;           // bit o = req[(ptr+o) mod NUM_REQ]
  logic                 win_vld;
  logic [ID_W-1:0]      win_idx;
  int                   cand;
  logic [6:0]           sel_addr;
  logic [7:0]           sel_data;
  logic [NUM_REQ-1:0]   id_onehot;
  logic [ID_W-1:0]      ptr_next;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             tmo_hit;
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  // Rotate requests so the search always starts at ptr; first set bit wins.
  assign req_dbl = {req, req} >> ptr_q;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  // Round-robin winner search over the rotated request vector.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!win_vld && req_rot[o]) begin
        win_vld = 1'b1;
        cand    = int'(ptr_q) + o;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        win_idx = ID_W'(cand);
      end
    end
  end

  // Mux the winner's address/data and decode the latched id to one-hot.
  always_comb begin
    sel_addr  = '0;
    sel_data  = '0;
    id_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        sel_addr = req_addr[7*i +: 7];
        sel_data = req_data[8*i +: 8];
      end
      if (id_q == ID_W'(i)) id_onehot[i] = 1'b1;
    end
  end

  // Pointer moves just past the winner, wrapping to requester 0.
  assign ptr_next = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    grant_d  = '0;
    start_d  = 1'b0;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    abort_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          id_d    = win_idx;
          addr_d  = sel_addr;
          data_d  = sel_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        grant_d = id_onehot;
        start_d = 1'b1;
        ptr_d   = ptr_next;
        state_d = S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // m_done has priority over a timeout expiring in the same cycle.
        if (m_done) begin
          err_d   = m_error;
          state_d = S_RESP;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP: begin
        rvalid_d = 1'b1;
        rerr_d   = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      grant_q  <= '0;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
      grant_q  <= grant_d;
      start_q  <= start_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  // WAIT-time counter and abort pulse register.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end
  assign m_abort = abort_q;
`else
  assign m_abort = 1'b0;
`endif

  assign grant      = grant_q;
  assign m_start    = start_q;
  assign m_addr     = addr_q;
  assign m_data     = data_q;
  assign resp_valid = rvalid_q;
  assign resp_id    = id_q;
  assign resp_error = rerr_q;

endmodule
